// File: rtl/bcd2bin_seq_if.sv
// Handshake bundle between the BCD digit source and the BCD-to-binary converter.
// master: drives start/bcd_in and observes results; slave: the converter.
interface bcd2bin_seq_if #(
  parameter int N  = 2,
  parameter int BW = 7
);
  logic           start;
  logic [4*N-1:0] bcd_in;
  logic           ready;
  logic           done_tick;
  logic [BW-1:0]  bin;
  logic           err;

  modport master (
    output start, bcd_in,
    input  ready, done_tick, bin, err
  );

  modport slave (
    input  start, bcd_in,
    output ready, done_tick, bin, err
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential N-digit BCD-to-binary converter (reverse double-dabble).
// Ports: clk, reset (sync, active-low), bus (start/bcd_in in; ready/done_tick/bin/err out).
module bcd2bin_seq #(
  parameter int N  = 2,
  parameter int BW = 7
) (
  input  logic         clk,
  input  logic         reset,
  bcd2bin_seq_if.slave bus
);

  localparam int CW = $clog2(BW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP,
    S_DONE
  } state_t;

  state_t         r_state, w_state;
  logic [4*N-1:0] r_bcd, w_bcd, w_sh_bcd;
  logic [BW-1:0]  r_acc, w_acc, w_sh_acc;
  logic [BW-1:0]  r_bin, w_bin;
  logic [CW-1:0]  r_n, w_n;
  logic           r_errn, w_errn;
  logic           r_err, w_err;
  logic           r_done, w_done;
  logic           w_bad;

  // Any non-decimal digit on the input.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  // One iteration: shift right, then take 3 off every digit >= 8.
  always_comb begin
    {w_sh_bcd, w_sh_acc} = {r_bcd, r_acc} >> 1;
    for (int i = 0; i < N; i++) begin
      if (w_sh_bcd[4*i+3])
        w_sh_bcd[4*i +: 4] = w_sh_bcd[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    w_state = r_state;
    w_bcd   = r_bcd;
    w_acc   = r_acc;
    w_n     = r_n;
    w_errn  = r_errn;
    w_bin   = r_bin;
    w_err   = r_err;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_acc  = '0;
          w_errn = 1'b0;
          if (w_bad) begin
            w_errn  = 1'b1;
            w_state = S_DONE;
          end else begin
            w_bcd   = bus.bcd_in;
            w_n     = CW'(BW);
            w_state = S_OP;
          end
        end
      end
      S_OP: begin
        w_bcd = w_sh_bcd;
        w_acc = w_sh_acc;
        w_n   = r_n - CW'(1);
        if (r_n == CW'(1)) w_state = S_DONE;
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_bin   = r_acc;
        w_err   = r_errn;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_bcd   <= '0;
      r_acc   <= '0;
      r_n     <= '0;
      r_errn  <= 1'b0;
      r_bin   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_bcd   <= w_bcd;
      r_acc   <= w_acc;
      r_n     <= w_n;
      r_errn  <= w_errn;
      r_bin   <= w_bin;
      r_err   <= w_err;
      r_done  <= w_done;
    end
  end

  // All BCD weight must have migrated into the accumulator.
  a_bcd_drained: assert property (
    @(posedge clk) disable iff (!reset)
    (r_state == S_OP && r_n == CW'(1)) |=> (r_bcd == '0)
  );

  assign bus.ready     = (r_state == S_IDLE);
  assign bus.done_tick = r_done;
  assign bus.bin       = r_bin;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: vector table, full valid sweep,
// and hand-written sequences for ignored start, mid-run reset and held start.
module tb_bcd2bin_seq;

  localparam int N  = 2;
  localparam int BW = 7;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  bcd2bin_seq_if #(.N(N), .BW(BW)) bus ();

  bcd2bin_seq #(.N(N), .BW(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bcd;
    int         bin;
    int         err;
    int         lat;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Issue one start and wait for done_tick; lat counts edges from the
  // accepting edge up to and including the one that raises done_tick.
  task automatic run(input logic [7:0] b, output int ob,
                     output int oe, output int lat);
    bus.bcd_in = b;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done_tick && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    ob = int'(bus.bin);
    oe = int'(bus.err);
  endtask

  initial begin
    int ob, oe, lat;
    int dt, rd0, bsave, last, nt, unstable;

    nvec = 0;
    nerr = 0;
    tbl[0] = '{8'h99, 99, 0, BW + 2};
    tbl[1] = '{8'h00,  0, 0, BW + 2};
    tbl[2] = '{8'h45, 45, 0, BW + 2};
    tbl[3] = '{8'hA5,  0, 1, 2};
    tbl[4] = '{8'h12, 12, 0, BW + 2};
    tbl[5] = '{8'h3F,  0, 1, 2};
    tbl[6] = '{8'h09,  9, 0, BW + 2};
    tbl[7] = '{8'h90, 90, 0, BW + 2};
    tbl[8] = '{8'hFF,  0, 1, 2};
    tbl[9] = '{8'h70, 70, 0, BW + 2};

    reset      = 1'b0;
    bus.start  = 1'b1;
    bus.bcd_in = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_done", int'(bus.done_tick), 0);
    chk("rst_bin", int'(bus.bin), 0);
    chk("rst_err", int'(bus.err), 0);
    bus.start = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run(tbl[i].bcd, ob, oe, lat);
      chk($sformatf("vec%0d_bin", i), ob, tbl[i].bin);
      chk($sformatf("vec%0d_err", i), oe, tbl[i].err);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      @(posedge clk); #1;
    end

    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        run({t[3:0], u[3:0]}, ob, oe, lat);
        chk($sformatf("sweep%0d%0d", t, u), ob, 10 * t + u);
        chk($sformatf("sweep%0d%0d_err", t, u), oe, 0);
      end
    end

    // Start pulsed mid-conversion is ignored; bcd_in change is ignored.
    bus.bcd_in = 8'h27;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dt = 0;
    rd0 = 0;
    bsave = -1;
    for (int k = 0; k < 20; k++) begin
      if (!bus.ready) rd0++;
      if (bus.done_tick) begin
        dt++;
        bsave = int'(bus.bin);
      end
      bus.start  = (k == 2);
      bus.bcd_in = (k >= 2) ? 8'h81 : 8'h27;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("ign_ticks", dt, 1);
    chk("ign_bin", bsave, 27);
    chk("ign_busy", rd0, BW + 1);

    // Reset in the middle of a conversion.
    bus.bcd_in = 8'h63;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_ready", int'(bus.ready), 1);
    chk("abort_bin", int'(bus.bin), 0);
    chk("abort_err", int'(bus.err), 0);
    dt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.done_tick) dt++;
    end
    chk("abort_ticks", dt, 0);
    run(8'h63, ob, oe, lat);
    chk("abort_rerun", ob, 63);
    chk("abort_rerun_lat", lat, BW + 2);

    // Start held high: back-to-back conversions.
    bus.bcd_in = 8'h50;
    bus.start  = 1'b1;
    last = -1;
    nt = 0;
    unstable = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.done_tick) begin
        chk("hold_bin", int'(bus.bin), 50);
        if (last >= 0) chk("hold_gap", k - last, BW + 2);
        last = k;
        nt++;
      end else if (nt > 0 && int'(bus.bin) != 50) begin
        unstable++;
      end
    end
    bus.start = 1'b0;
    chk("hold_ticks", nt, 2);
    chk("hold_stable", unstable, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("end_ready", int'(bus.ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
